// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: single-port 64-bit memory responder on the cbus.
//   clk    : clock, all state changes on posedge
//   reset  : asynchronous active-high reset (memory contents survive it)
//   creq   : request bus (valid, is_write, addr, strobe, data, len, burst; size unused)
//   cresp  : response bus (ready, last, data)
// A request is latched in IDLE, waits LATENCY cycles, then streams len+1 beats
// with no backpressure. Dropping creq.valid mid-transaction aborts to IDLE.
// The backing store is split into byte lanes so strobes map to per-lane enables.

package cbus_pkg;
  localparam int CBUS_LEN_W = 8;

  typedef enum logic {BURST_FIXED = 1'b0, BURST_INCR = 1'b1} cbus_burst_e;

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    logic [31:0]           addr;
    logic [2:0]            size;
    logic [CBUS_LEN_W-1:0] len;
    cbus_burst_e           burst;
    logic [7:0]            strobe;
    logic [63:0]           data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// One byte lane of the backing store: sync write, async read.
module cbus_mem_lane #(
  parameter int ADDR_WIDTH = 12,
  parameter int VEC_W      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [VEC_W-1:0]      wdata,
  output logic [VEC_W-1:0]      rdata
);
  logic [VEC_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;
  // WAIT holds for LATENCY cycles; the counter is loaded with LATENCY-1 so
  // that the zero test on the last WAIT cycle steers into BURST.
  localparam logic [3:0]            WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = 1;
  localparam logic [CBUS_LEN_W-1:0] CNT_ONE   = 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CBUS_LEN_W-1:0] len_q;
  logic [CBUS_LEN_W-1:0] beat_cnt;   // same width as len: len=max cannot overflow
  logic [3:0]            wait_cnt;
  logic                  incr_q, wr_q;
  logic                  in_burst, last_beat, beat_we;
  logic [NUM_LANES-1:0][VEC_W-1:0] rdata;
  logic                  unused_bits;

  assign in_burst  = (state == BURST);
  assign last_beat = in_burst && (beat_cnt == len_q);
  // A beat presented with valid low is the abort cycle and must not write.
  assign beat_we   = in_burst && wr_q && creq.valid;

  assign unused_bits = ^{creq.size, creq.addr[31:ADDR_WIDTH+3], creq.addr[2:0]};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    cbus_mem_lane #(.ADDR_WIDTH(ADDR_WIDTH), .VEC_W(VEC_W)) u_lane (
      .clk   (clk),
      .we    (beat_we && creq.strobe[l]),
      .idx   (idx),
      .wdata (creq.data[l*VEC_W +: VEC_W]),
      .rdata (rdata[l])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      incr_q   <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (creq.valid) begin
          idx      <= creq.addr[ADDR_WIDTH+2:3];
          len_q    <= creq.len;
          incr_q   <= (creq.burst == BURST_INCR);
          wr_q     <= creq.is_write;
          beat_cnt <= '0;
          wait_cnt <= WAIT_INIT;
        end
        WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        BURST: begin
          beat_cnt <= beat_cnt + CNT_ONE;
          if (incr_q) idx <= idx + IDX_ONE;   // wraps modulo 2^ADDR_WIDTH
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cresp   = '0;
    unique case (state)
      IDLE:  if (creq.valid) state_n = (LATENCY == 0) ? BURST : WAIT;
      WAIT:  if (!creq.valid) state_n = IDLE;
             else if (wait_cnt == 4'd0) state_n = BURST;
      BURST: if (!creq.valid || last_beat) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (in_burst) begin
      cresp.ready = 1'b1;
      cresp.last  = last_beat;
      cresp.data  = wr_q ? 64'd0 : rdata;
    end
  end
endmodule

// File: tb/tb_cbus_mem_responder.sv
module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int AW  = 12;
  localparam int LAT = 2;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [0:(1<<AW)-1];
  logic [63:0] wbuf  [0:15];
  exp_t        sbq [$];

  cbus_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .creq  (creq),
    .cresp (cresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every accepted beat pops one expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && cresp.ready && creq.valid) begin
      if (sbq.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("rdata", cresp.data, e.d);
        chk("last", {63'd0, cresp.last}, {63'd0, e.l});
      end
    end
  end

  // Called at the start of a cycle where the DUT is IDLE. keep=1 leaves valid
  // high into the idle cycle after last; abort_at>=0 drops valid on that beat.
  task automatic burst(input bit wr, input logic [31:0] addr, input int len,
                       input bit incr, input logic [7:0] strb,
                       input bit keep, input int abort_at);
    logic [AW-1:0] idx;
    exp_t e;
    int nb;
    idx = addr[AW+2:3];
    nb  = (abort_at >= 0) ? abort_at : len + 1;
    for (int b = 0; b < nb; b++) begin
      if (wr) begin
        for (int i = 0; i < 8; i++)
          if (strb[i]) model[idx][8*i +: 8] = wbuf[b][8*i +: 8];
        e.d = 64'd0;
      end else e.d = model[idx];
      e.l = (b == len);
      sbq.push_back(e);
      if (incr) idx = idx + 1'b1;
    end
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.addr     = addr;
    creq.len      = 8'(len);
    creq.burst    = incr ? BURST_INCR : BURST_FIXED;
    creq.strobe   = strb;
    creq.data     = wbuf[0];
    @(negedge clk);
    chk("acc_rdy", {63'd0, cresp.ready}, 64'd0);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("wait_rdy", {63'd0, cresp.ready}, 64'd0);
      chk("wait_data", cresp.data, 64'd0);
    end
    for (int b = 0; b <= len; b++) begin
      @(posedge clk); #1;
      creq.data = wbuf[b];
      if (b == abort_at) begin
        creq.valid = 1'b0;
        break;
      end
      @(negedge clk);
      chk("beat_rdy", {63'd0, cresp.ready}, 64'd1);
    end
    @(posedge clk); #1;
    if (!keep) begin
      creq.valid = 1'b0;
      @(negedge clk);
      chk("idle_rdy", {63'd0, cresp.ready}, 64'd0);
      chk("idle_last", {63'd0, cresp.last}, 64'd0);
      chk("idle_data", cresp.data, 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    creq  = '0;
    reset = 1'b1;
    for (int i = 0; i < (1<<AW); i++) model[i] = 64'd0;
    #1;
    chk("rst_rdy", {63'd0, cresp.ready}, 64'd0);
    chk("rst_last", {63'd0, cresp.last}, 64'd0);
    chk("rst_data", cresp.data, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Write then read, INCR, high/low address bits ignored.
    wbuf[0] = {8{8'h11}}; wbuf[1] = {8{8'h22}};
    wbuf[2] = {8{8'h33}}; wbuf[3] = {8{8'h44}};
    burst(1, 32'h8000_0040, 3, 1, 8'hFF, 0, -1);
    burst(0, 32'h8000_0040, 3, 1, 8'hFF, 0, -1);
    chk("raw_model_w8", model[8], {8{8'h11}});

    // Partial strobe.
    wbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    burst(1, 32'h0000_0028, 0, 1, 8'hFF, 0, -1);
    wbuf[0] = 64'h0000_0000_1234_5678;
    burst(1, 32'h0000_0028, 0, 1, 8'h0F, 0, -1);
    chk("strobe_model", model[5], 64'hAAAA_AAAA_1234_5678);
    burst(0, 32'h0000_0028, 0, 1, 8'hFF, 0, -1);

    // FIXED burst: last write wins, read repeats it.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
    burst(1, 32'h0000_00A0, 3, 0, 8'hFF, 0, -1);
    burst(0, 32'h0000_00A0, 3, 0, 8'hFF, 0, -1);

    // Wrap-around: index 4094 -> 4094, 4095, 0, 1.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    burst(1, 32'hF000_7FF3, 3, 1, 8'hFF, 0, -1);
    chk("wrap_model0", model[0], 64'hC0DE_0000_0000_0002);
    burst(0, 32'h0000_7FF0, 3, 1, 8'hFF, 0, -1);

    // Abort on beat 2 of a 4-beat write over a known pattern.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h5555_0000_0000_0000 | 64'(i);
    burst(1, 32'h0000_0640, 3, 1, 8'hFF, 0, -1);
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h9999_0000_0000_0000 | 64'(i);
    burst(1, 32'h0000_0640, 3, 1, 8'hFF, 0, 2);
    burst(0, 32'h0000_0640, 3, 1, 8'hFF, 0, -1);

    // Reset mid-WAIT.
    creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = 32'h0000_0040;
    creq.len = 8'd3; creq.burst = BURST_INCR;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midwait_rst_rdy", {63'd0, cresp.ready}, 64'd0);
    creq.valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_rdy", {63'd0, cresp.ready}, 64'd0);
    end
    @(posedge clk); #1 reset = 1'b0;
    burst(0, 32'h0000_0040, 3, 1, 8'hFF, 0, -1);

    // Back-to-back: write writeback then read fetch accepted in the idle cycle.
    wbuf[0] = 64'hFEED_FACE_0000_0001; wbuf[1] = 64'hFEED_FACE_0000_0002;
    burst(1, 32'h0000_0320, 1, 1, 8'hFF, 1, -1);
    burst(0, 32'h0000_0320, 1, 1, 8'hFF, 0, -1);

    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cbus_mem_responder.md
CBUS_MEM_RESPONDER -- requirements
Module: cbus_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: log2 of the number of 64-bit words in the backing store.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles between request acceptance and the first beat, legal range 0..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port creq  input  cbus_req_t  request bus.
  - Fields used: valid, is_write, addr, strobe, data, len, burst.
  - size is ignored.
REQ-006 SHALL have port cresp  output  cbus_resp_t  response bus with fields ready, last, data.

Function
REQ-007 SHALL implement a three-state FSM: IDLE, WAIT, BURST.
REQ-008 IDLE: when creq.valid=1, SHALL latch the following, then go to WAIT (LATENCY>0) or BURST (LATENCY=0):
  - word index = addr[ADDR_WIDTH+2:3]; addr[2:0] and all higher bits are ignored.
  - len, burst and is_write.
REQ-009 WAIT: SHALL count down LATENCY cycles with cresp.ready=0, then enter BURST; the first beat is in cycle LATENCY+1, where the acceptance cycle is cycle 0.
REQ-010 BURST: SHALL assert cresp.ready=1 for exactly len+1 consecutive cycles, one beat per cycle; the initiator cannot stall.
REQ-011 SHALL assert cresp.last only on the beat where beat count equals latched len; on the next cycle SHALL return to IDLE.
  - This gives at least one idle cycle between bursts.
REQ-012 Read beat: cresp.data SHALL equal mem[current index], read combinationally in the same cycle as ready.
REQ-013 Write beat: on posedge, SHALL write each byte i of creq.data to mem[current index] where creq.strobe[i]=1; other bytes are unchanged.
  - cresp.data SHALL be 0 on write beats.
REQ-014 INCR burst: index SHALL increment by 1 per beat, wrapping modulo 2^ADDR_WIDTH.
REQ-015 FIXED burst: index SHALL stay constant for all beats.
REQ-016 The beat counter SHALL be at least as wide as len, so len=max never overflows before last.
REQ-017 cresp.ready, cresp.last and cresp.data SHALL all be 0 whenever the FSM is not in BURST.
REQ-018 If creq.valid drops to 0 in WAIT or BURST:
  - SHALL abort to IDLE on the next cycle.
  - The current-cycle beat with valid=0 SHALL NOT be written.
  - No further beats are issued.
REQ-019 A request whose creq.valid is held high through the idle cycle after last SHALL be accepted in that idle cycle as a new request.
  - This supports writeback followed directly by fetch.
REQ-020 Read-after-write: a read burst SHALL return data written by any earlier completed write beat, including the immediately preceding burst.

Reset
REQ-021 On reset assertion, asynchronously and independent of clk:
  - FSM SHALL go to IDLE, counters to 0, and cresp.ready, cresp.last and cresp.data to 0.
REQ-022 Reset SHALL NOT clear memory contents; a write burst interrupted by reset keeps only the beats completed before reset.
REQ-023 After reset deasserts, the first request SHALL be accepted on the first posedge where creq.valid=1.

Verification
REQ-024 Write then read, INCR, LATENCY=2:
  - Write addr 0x80000040, len=3, strobe 0xFF, data 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Then read the same range.
  - Expected: ready in cycles 3-6 of each burst, last in cycle 6, read data in write order.
REQ-025 Partial strobe:
  - Word at index 5 holds 0xAAAAAAAAAAAAAAAA.
  - Write index 5 with len=0, strobe 0x0F, data 0x0000000012345678.
  - Expected read-back: 0xAAAAAAAA12345678.
REQ-026 FIXED burst: write len=3 to one address with data 1, 2, 3, 4 -> a read returns 4 on all four beats.
REQ-027 Wrap-around: INCR read of len=3 starting at index 2^ADDR_WIDTH-2 -> accesses indices 4094, 4095, 0, 1 (ADDR_WIDTH=12).
REQ-028 Abort and reset:
  - Drop valid on beat 2 of a 4-beat write -> only beats 0-1 are written, FSM returns to IDLE, ready=0 the next cycle.
  - Assert reset mid-WAIT -> ready stays 0 and the next request is served normally.
REQ-029 Back-to-back: after last of a write, hold valid high with a new read address -> accepted in the idle cycle, first read beat LATENCY+1 cycles later.
